// File: rtl/bsg_async_fifo_rptr_ctrl.sv
// Read-side pointer control for an asynchronous FIFO.
// Tracks the synchronized write pointer and produces the read pointers, occupancy and error flags.
module bsg_async_fifo_rptr_ctrl #(
    parameter int lg_size_p = 6
) (
    input  logic                 clk_i,
    input  logic                 reset_n_i,
    input  logic [lg_size_p-1:0] w_ptr_gray_rsync_i,
    input  logic                 yumi_i,
    output logic                 v_o,
    output logic [lg_size_p-2:0] r_addr_o,
    output logic [lg_size_p-1:0] r_ptr_binary_r_o,
    output logic [lg_size_p-1:0] r_ptr_gray_r_o,
    output logic [lg_size_p-1:0] count_o,
    output logic                 underflow_o,
    output logic                 ptr_err_o
);

    localparam logic [lg_size_p-1:0] depth_lp = {1'b1, {(lg_size_p-1){1'b0}}};

    logic [lg_size_p-1:0] w_bin_d, w_bin_q;
    logic [lg_size_p-1:0] r_bin_d, r_bin_q;
    logic [lg_size_p-1:0] r_gray_d, r_gray_q;
    logic                 underflow_d, underflow_q;
    logic                 ptr_err_d, ptr_err_q;
    logic                 deq;
    logic [lg_size_p-1:0] count;

    // Output-side decode uses registered state only, so yumi_i never reaches v_o.
    always_comb begin
        count = w_bin_q - r_bin_q;
    end

    assign v_o              = (w_bin_q != r_bin_q);
    assign count_o          = count;
    assign r_addr_o         = r_bin_q[lg_size_p-2:0];
    assign r_ptr_binary_r_o = r_bin_q;
    assign r_ptr_gray_r_o   = r_gray_q;
    assign underflow_o      = underflow_q;
    assign ptr_err_o        = ptr_err_q;
    assign deq              = yumi_i & v_o;

    // Bit i of the binary value is the XOR of all Gray bits at or above i.
    always_comb begin
        w_bin_d = '0;
        for (int i = 0; i < lg_size_p; i++) begin
            w_bin_d[i] = ^(w_ptr_gray_rsync_i >> i);
        end
    end

    always_comb begin
        r_bin_d     = r_bin_q;
        r_gray_d    = r_gray_q;
        underflow_d = underflow_q;
        ptr_err_d   = ptr_err_q;
        if (deq) begin
            r_bin_d = r_bin_q + 1'b1;
        end
        // Gray is computed from the next binary value so the flop holds it directly.
        r_gray_d = r_bin_d ^ (r_bin_d >> 1);
        if (yumi_i && !v_o) begin
            underflow_d = 1'b1;
        end
        if (count > depth_lp) begin
            ptr_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            w_bin_q     <= '0;
            r_bin_q     <= '0;
            r_gray_q    <= '0;
            underflow_q <= 1'b0;
            ptr_err_q   <= 1'b0;
        end else begin
            w_bin_q     <= w_bin_d;
            r_bin_q     <= r_bin_d;
            r_gray_q    <= r_gray_d;
            underflow_q <= underflow_d;
            ptr_err_q   <= ptr_err_d;
        end
    end

endmodule

// File: tb/tb_bsg_async_fifo_rptr_ctrl.sv
// Directed testbench for bsg_async_fifo_rptr_ctrl (default lg_size_p = 6).
module tb_bsg_async_fifo_rptr_ctrl;

    localparam int W = 6;

    logic         clk = 1'b0;
    logic         reset_n = 1'b0;
    logic [W-1:0] w_gray = '0;
    logic         yumi = 1'b0;
    logic         v;
    logic [W-2:0] r_addr;
    logic [W-1:0] r_bin;
    logic [W-1:0] r_gray;
    logic [W-1:0] count;
    logic         underflow;
    logic         ptr_err;

    int passed = 0;
    int total  = 0;

    bsg_async_fifo_rptr_ctrl #(.lg_size_p(W)) dut (
        .clk_i              (clk),
        .reset_n_i          (reset_n),
        .w_ptr_gray_rsync_i (w_gray),
        .yumi_i             (yumi),
        .v_o                (v),
        .r_addr_o           (r_addr),
        .r_ptr_binary_r_o   (r_bin),
        .r_ptr_gray_r_o     (r_gray),
        .count_o            (count),
        .underflow_o        (underflow),
        .ptr_err_o          (ptr_err)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] to_gray(input int b);
        logic [W-1:0] x;
        x = W'(b);
        return x ^ (x >> 1);
    endfunction

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        yumi    = 1'b0;
        w_gray  = '0;
        step();
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        reset_n = 1'b0;
        yumi    = 1'b1;
        w_gray  = '0;
        step();
        total++; if (underflow !== 1'b0) $display("FAIL rst_yumi_underflow got %0b exp 0", underflow); else passed++;
        reset_n = 1'b1;
        yumi    = 1'b0;
        step();
        total++; if (v !== 1'b0) $display("FAIL rst_v got %0b exp 0", v); else passed++;
        total++; if (count !== 6'd0) $display("FAIL rst_count got %0d exp 0", count); else passed++;
        total++; if (r_bin !== 6'd0) $display("FAIL rst_rbin got %0d exp 0", r_bin); else passed++;
        total++; if (r_gray !== 6'd0) $display("FAIL rst_rgray got %b exp 000000", r_gray); else passed++;
        total++; if (r_addr !== 5'd0) $display("FAIL rst_addr got %0d exp 0", r_addr); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL rst_underflow got %0b exp 0", underflow); else passed++;
        total++; if (ptr_err !== 1'b0) $display("FAIL rst_ptr_err got %0b exp 0", ptr_err); else passed++;
    endtask

    task automatic test_single();
        do_reset();
        w_gray = 6'b000001;
        #1;
        total++; if (v !== 1'b0) $display("FAIL single_v_before_edge got %0b exp 0", v); else passed++;
        @(negedge clk);
        total++; if (v !== 1'b1) $display("FAIL single_v got %0b exp 1", v); else passed++;
        total++; if (count !== 6'd1) $display("FAIL single_count got %0d exp 1", count); else passed++;
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        total++; if (r_bin !== 6'd1) $display("FAIL single_rbin got %0d exp 1", r_bin); else passed++;
        total++; if (r_gray !== 6'b000001) $display("FAIL single_rgray got %b exp 000001", r_gray); else passed++;
        total++; if (v !== 1'b0) $display("FAIL single_v_empty got %0b exp 0", v); else passed++;
        total++; if (count !== 6'd0) $display("FAIL single_count_empty got %0d exp 0", count); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL single_underflow got %0b exp 0", underflow); else passed++;
    endtask

    task automatic test_full_err();
        do_reset();
        w_gray = 6'b110000;
        step();
        total++; if (count !== 6'd32) $display("FAIL full_count got %0d exp 32", count); else passed++;
        total++; if (v !== 1'b1) $display("FAIL full_v got %0b exp 1", v); else passed++;
        total++; if (r_addr !== 5'd0) $display("FAIL full_addr got %0d exp 0", r_addr); else passed++;
        step();
        total++; if (ptr_err !== 1'b0) $display("FAIL full_ptr_err got %0b exp 0", ptr_err); else passed++;
        w_gray = 6'b110001;
        step();
        total++; if (count !== 6'd33) $display("FAIL over_count got %0d exp 33", count); else passed++;
        total++; if (ptr_err !== 1'b0) $display("FAIL over_ptr_err_early got %0b exp 0", ptr_err); else passed++;
        step();
        total++; if (ptr_err !== 1'b1) $display("FAIL over_ptr_err got %0b exp 1", ptr_err); else passed++;
        w_gray = 6'b000000;
        step();
        step();
        total++; if (count !== 6'd0) $display("FAIL err_hold_count got %0d exp 0", count); else passed++;
        total++; if (ptr_err !== 1'b1) $display("FAIL err_hold got %0b exp 1", ptr_err); else passed++;
    endtask

    task automatic test_wrap();
        logic [W-1:0] prev;
        int bad;
        do_reset();
        bad  = 0;
        prev = '0;
        for (int i = 0; i < 64; i++) begin
            w_gray = to_gray(i + 1);
            step();
            if (v !== 1'b1 || count !== 6'd1 || r_addr !== 5'(i % 32)) begin
                $display("FAIL wrap_pre i=%0d got v=%0b cnt=%0d addr=%0d exp v=1 cnt=1 addr=%0d",
                         i, v, count, r_addr, i % 32);
                bad++;
            end
            yumi = 1'b1;
            step();
            yumi = 1'b0;
            if (r_bin !== 6'((i + 1) % 64) || r_gray !== to_gray((i + 1) % 64) || v !== 1'b0) begin
                $display("FAIL wrap_post i=%0d got rbin=%0d rgray=%b v=%0b exp rbin=%0d rgray=%b v=0",
                         i, r_bin, r_gray, v, (i + 1) % 64, to_gray((i + 1) % 64));
                bad++;
            end
            if ($countones(r_gray ^ prev) != 1) begin
                $display("FAIL wrap_gray_step i=%0d got %b from %b exp one bit change", i, r_gray, prev);
                bad++;
            end
            if (i == 62 && r_gray !== 6'b100000) begin
                $display("FAIL wrap_gray63 got %b exp 100000", r_gray);
                bad++;
            end
            prev = r_gray;
        end
        total++; if (bad != 0) $display("FAIL wrap_seq got %0d errors exp 0", bad); else passed++;
        total++; if (r_bin !== 6'd0) $display("FAIL wrap_rbin got %0d exp 0", r_bin); else passed++;
        total++; if (r_gray !== 6'b000000) $display("FAIL wrap_rgray got %b exp 000000", r_gray); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL wrap_underflow got %0b exp 0", underflow); else passed++;
    endtask

    task automatic test_back_to_back();
        do_reset();
        w_gray = to_gray(2);
        step();
        total++; if (count !== 6'd2) $display("FAIL b2b_count0 got %0d exp 2", count); else passed++;
        w_gray = to_gray(3);
        yumi   = 1'b1;
        step();
        yumi = 1'b0;
        total++; if (count !== 6'd2) $display("FAIL b2b_count1 got %0d exp 2", count); else passed++;
        total++; if (r_bin !== 6'd1) $display("FAIL b2b_rbin got %0d exp 1", r_bin); else passed++;
        total++; if (r_addr !== 5'd1) $display("FAIL b2b_addr got %0d exp 1", r_addr); else passed++;
        yumi = 1'b1;
        step();
        step();
        yumi = 1'b0;
        total++; if (r_bin !== 6'd3) $display("FAIL b2b_drain_rbin got %0d exp 3", r_bin); else passed++;
        total++; if (r_gray !== 6'b000010) $display("FAIL b2b_drain_rgray got %b exp 000010", r_gray); else passed++;
        total++; if (v !== 1'b0) $display("FAIL b2b_drain_v got %0b exp 0", v); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL b2b_underflow got %0b exp 0", underflow); else passed++;
    endtask

    task automatic test_underflow();
        do_reset();
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        total++; if (r_bin !== 6'd0) $display("FAIL uf_rbin got %0d exp 0", r_bin); else passed++;
        total++; if (r_gray !== 6'd0) $display("FAIL uf_rgray got %b exp 000000", r_gray); else passed++;
        total++; if (underflow !== 1'b1) $display("FAIL uf_set got %0b exp 1", underflow); else passed++;
        step();
        step();
        total++; if (underflow !== 1'b1) $display("FAIL uf_hold got %0b exp 1", underflow); else passed++;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        total++; if (underflow !== 1'b0) $display("FAIL uf_clear got %0b exp 0", underflow); else passed++;
    endtask

    task automatic test_reset_mid();
        do_reset();
        w_gray = to_gray(5);
        step();
        total++; if (count !== 6'd5) $display("FAIL mid_count got %0d exp 5", count); else passed++;
        reset_n = 1'b0;
        yumi    = 1'b1;
        #1;
        total++; if (count !== 6'd5) $display("FAIL mid_async_count got %0d exp 5", count); else passed++;
        total++; if (v !== 1'b1) $display("FAIL mid_async_v got %0b exp 1", v); else passed++;
        step();
        total++; if (v !== 1'b0) $display("FAIL mid_v got %0b exp 0", v); else passed++;
        total++; if (count !== 6'd0) $display("FAIL mid_count_rst got %0d exp 0", count); else passed++;
        total++; if (r_bin !== 6'd0) $display("FAIL mid_rbin got %0d exp 0", r_bin); else passed++;
        total++; if (r_gray !== 6'd0) $display("FAIL mid_rgray got %b exp 000000", r_gray); else passed++;
        total++; if (underflow !== 1'b0) $display("FAIL mid_underflow got %0b exp 0", underflow); else passed++;
        total++; if (ptr_err !== 1'b0) $display("FAIL mid_ptr_err got %0b exp 0", ptr_err); else passed++;
        reset_n = 1'b1;
        yumi    = 1'b0;
        w_gray  = '0;
        step();
    endtask

    initial begin
        test_reset();
        test_single();
        test_full_err();
        test_wrap();
        test_back_to_back();
        test_underflow();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
